// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the multiport register file.
// Holds the default geometry and the clear-FSM state encoding
// used by regfile_multiport and regfile_clear_seq.
package regfile_multiport_pkg;

    localparam int RISC_V_DATA_WIDTH           = 32;
    localparam int REGISTER_FILE_ADDRESS_WIDTH = 5;
    localparam int REGISTER_FILE_NUM           = 2;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for the register file.
// After reset, or on clear_req while ready, walks every entry index from 0
// up to DEPTH-1 (one per cycle) and then reports ready.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (restarts the walk at 0)
//   clear_req  - start a new walk; ignored while a walk is in progress
//   ready      - high when no walk is in progress
//   clear_we   - zero entry clear_addr this cycle
//   clear_addr - entry being zeroed
module regfile_clear_seq
    import regfile_multiport_pkg::*;
#(
    parameter int ADDR_WIDTH = REGISTER_FILE_ADDRESS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    rf_state_e             r_state;
    rf_state_e             w_next_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_next_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            RF_CLEAR: begin
                // The last index is all ones, so the wrap back to 0 lines up
                // with the move to READY.
                if (r_cnt == '1) begin
                    w_next_state = RF_READY;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            RF_READY: begin
                w_next_cnt = '0;
                if (clear_req) begin
                    w_next_state = RF_CLEAR;
                end
            end
            default: begin
                w_next_state = RF_CLEAR;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        ready      = (r_state == RF_READY);
        clear_we   = (r_state == RF_CLEAR);
        clear_addr = r_cnt;
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with pending-bit scoreboard.
// Entry 0 is hard-wired to zero. NUM_READ registered read ports with
// write-first bypass of both data and pending bit. Contents are zeroed by a
// one-entry-per-cycle clear walk after reset or on clear_req.
// Optional feature macro: REGFILE_DEBUG_EN adds a 16-bit debug output that
// shows bits [15:0] of the highest entry.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   clear_req, ready    - start clear walk / array usable
//   rd_addr, rd_data    - packed read indices and registered read data
//   rd_pending          - registered pending bit per read port
//   wr_en/addr/data     - write port (also clears the pending bit)
//   sb_set, sb_addr     - mark an entry pending
//   debug               - (REGFILE_DEBUG_EN only) entry DEPTH-1 bits [15:0]
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_WIDTH = RISC_V_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGISTER_FILE_ADDRESS_WIDTH,
    parameter int NUM_READ   = REGISTER_FILE_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_req,
    output logic                           ready,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_pending,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           sb_set,
    input  logic [ADDR_WIDTH-1:0]          sb_addr
`ifdef REGFILE_DEBUG_EN
    ,
    output logic [15:0]                    debug
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
    logic [DEPTH-1:0]               r_pending;
    logic [NUM_READ*DATA_WIDTH-1:0] r_rd_data;
    logic [NUM_READ-1:0]            r_rd_pending;

    logic                           w_ready;
    logic                           w_clear_we;
    logic [ADDR_WIDTH-1:0]          w_clear_addr;
    logic                           w_wr_ok;
    logic                           w_sb_ok;
    logic [NUM_READ*DATA_WIDTH-1:0] w_nxt_data;
    logic [NUM_READ-1:0]            w_nxt_pend;

    regfile_clear_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (w_ready),
        .clear_we  (w_clear_we),
        .clear_addr(w_clear_addr)
    );

    // Writes and scoreboard sets only take effect while usable; index 0 is
    // never stored so it stays a constant zero.
    assign w_wr_ok = w_ready && !rst && wr_en  && (wr_addr != '0);
    assign w_sb_ok = w_ready && !rst && sb_set && (sb_addr != '0);

    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[w_clear_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so that a same-index set wins.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_pending[w_clear_addr] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pending[wr_addr] <= 1'b0;
            end
            if (w_sb_ok) begin
                r_pending[sb_addr] <= 1'b1;
            end
        end
    end

    // Next read values per port: array contents overridden by this cycle's
    // write (data and pending clear) and then by this cycle's set.
    always_comb begin
        logic [ADDR_WIDTH-1:0] v_addr;
        v_addr     = '0;
        w_nxt_data = '0;
        w_nxt_pend = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            v_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_nxt_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[v_addr];
            w_nxt_pend[k] = r_pending[v_addr];
            if (w_wr_ok && (wr_addr == v_addr)) begin
                w_nxt_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                w_nxt_pend[k] = 1'b0;
            end
            if (w_sb_ok && (sb_addr == v_addr)) begin
                w_nxt_pend[k] = 1'b1;
            end
            if (v_addr == '0) begin
                w_nxt_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                w_nxt_pend[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_ready) begin
            r_rd_data    <= '0;
            r_rd_pending <= '0;
        end else begin
            r_rd_data    <= w_nxt_data;
            r_rd_pending <= w_nxt_pend;
        end
    end

    assign ready      = w_ready;
    assign rd_data    = r_rd_data;
    assign rd_pending = r_rd_pending;

`ifdef REGFILE_DEBUG_EN
    assign debug = r_mem[DEPTH-1][15:0];
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst;
    logic             clear_req;
    logic             ready;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_pending;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
`ifdef REGFILE_DEBUG_EN
    logic [15:0]      debug;
`endif

    regfile_multiport #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_READ  (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pending(rd_pending),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr)
`ifdef REGFILE_DEBUG_EN
        ,
        .debug     (debug)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of entries and pending flags.
    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];
    logic [DW-1:0] e_data [NR];
    logic          e_pend [NR];

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ss;
        logic [AW-1:0] sa;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic          p0;
        logic [DW-1:0] d1;
        logic          p1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ss, input logic [AW-1:0] sa,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        sb_set  = ss;
        sb_addr = sa;
        rd_addr = {a1, a0};
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Expected read results for the currently driven inputs (ready state),
    // then commit the write/set to the model and advance one clock.
    task automatic model_step();
        logic [AW-1:0] a [NR];
        a[0] = rd_addr[AW-1:0];
        a[1] = rd_addr[2*AW-1:AW];
        for (int k = 0; k < NR; k++) begin
            if (a[k] == 0) begin
                e_data[k] = '0;
                e_pend[k] = 1'b0;
            end else begin
                e_data[k] = (wr_en && wr_addr == a[k]) ? wr_data : m_mem[a[k]];
                if (sb_set && sb_addr == a[k])      e_pend[k] = 1'b1;
                else if (wr_en && wr_addr == a[k])  e_pend[k] = 1'b0;
                else                                e_pend[k] = m_pend[a[k]];
            end
        end
        if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
        end
        if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int bad;

        rst = 1'b1;
        clear_req = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);

        // Reset and initial clear walk
        tick();
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_rd_pending", {62'd0, rd_pending}, 64'd0);
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (!ready && n < 100) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
            n++;
            if (rd_data != '0 || rd_pending != '0) bad++;
        end
        chk("reset_ready_latency", 64'(n), 64'd32);
        chk("reads_zero_while_clearing", 64'(bad), 64'd0);
        model_clear();

        // Directed vectors, applied in order from an all-zero array
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd1,  5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0, 5'd7,  5'd5, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd7, 32'h0,        1'b0, 32'h12345678, 1'b0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3,  5'd0, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd3, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[6] = '{1'b1, 5'd3,  32'h1,        1'b0, 5'd0, 5'd3,  5'd0, 32'h1,        1'b0, 32'h0,        1'b0};
        tbl[7] = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd3, 5'd3,  5'd3, 32'h1,        1'b1, 32'h1,        1'b1};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd7, 32'h1,        1'b1, 32'h12345678, 1'b0};
        tbl[9] = '{1'b1, 5'd31, 32'hCAFE0001, 1'b0, 5'd0, 5'd31, 5'd0, 32'hCAFE0001, 1'b0, 32'h0,        1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ss, tbl[i].sa, tbl[i].a0, tbl[i].a1);
            model_step();
            chk($sformatf("vec%0d_data0", i), 64'(rd_data[DW-1:0]), 64'(tbl[i].d0));
            chk($sformatf("vec%0d_data1", i), 64'(rd_data[2*DW-1:DW]), 64'(tbl[i].d1));
            chk($sformatf("vec%0d_pend", i), {62'd0, rd_pending}, {62'd0, tbl[i].p1, tbl[i].p0});
        end

        // Random traffic against the model; writes stay below 16 so x31 keeps
        // its value for the clear sequence.
        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] wa, sa, a0, a1;
            wa = 5'($urandom_range(0, 15));
            sa = ($urandom % 3 == 0) ? wa : 5'($urandom_range(0, 15));
            a0 = ($urandom % 3 == 0) ? wa : 5'($urandom_range(0, 31));
            a1 = ($urandom % 4 == 0) ? a0 : 5'($urandom_range(0, 31));
            drive(1'($urandom), wa, $urandom, 1'($urandom), sa, a0, a1);
            model_step();
            chk("rand_data0", 64'(rd_data[DW-1:0]), 64'(e_data[0]));
            chk("rand_data1", 64'(rd_data[2*DW-1:DW]), 64'(e_data[1]));
            chk("rand_pend", {62'd0, rd_pending}, {62'd0, e_pend[1], e_pend[0]});
        end

        // clear_req: held a few cycles (must not restart), write mid-walk ignored
`ifdef REGFILE_DEBUG_EN
        chk("debug_before_clear", 64'(debug), 64'h0001);
`endif
        drive(1'b0, '0, '0, 1'b0, '0, 5'd31, 5'd9);
        clear_req = 1'b1;
        tick();
        chk("clear_ready_low", {63'd0, ready}, 64'd0);
        n = 0;
        bad = 0;
        while (!ready && n < 100) begin
            clear_req = (n < 4);
            if (n == 20) drive(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 5'd31, 5'd9);
            else         drive(1'b0, '0, '0, 1'b0, '0, 5'd31, 5'd9);
            tick();
            n++;
            if (rd_data != '0 || rd_pending != '0) bad++;
        end
        clear_req = 1'b0;
        chk("clear_ready_latency", 64'(n), 64'd32);
        chk("clear_reads_zero", 64'(bad), 64'd0);
        model_clear();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd31, 5'd9);
        tick();
        chk("after_clear_x31", 64'(rd_data[DW-1:0]), 64'd0);
        chk("after_clear_x9", 64'(rd_data[2*DW-1:DW]), 64'd0);
        chk("after_clear_pend", {62'd0, rd_pending}, 64'd0);
`ifdef REGFILE_DEBUG_EN
        chk("debug_after_clear", 64'(debug), 64'h0000);
`endif

        // rst at clear cycle 10 restarts the walk
        drive(1'b1, 5'd12, 32'h5, 1'b0, '0, '0, '0);
        model_step();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        chk("midclear_rst_ready", {63'd0, ready}, 64'd0);
        chk("midclear_rst_data", rd_data, 64'd0);
        rst = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            if (n == 5) drive(1'b1, 5'd1, 32'h55, 1'b0, '0, 5'd12, 5'd1);
            else        drive(1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd1);
            tick();
            n++;
        end
        chk("midclear_ready_latency", 64'(n), 64'd32);
        model_clear();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd1);
        tick();
        chk("midclear_x12_zero", 64'(rd_data[DW-1:0]), 64'd0);
        chk("midclear_x1_write_ignored", 64'(rd_data[2*DW-1:DW]), 64'd0);

        // Short random run after recovery
        for (int i = 0; i < 50; i++) begin
            logic [AW-1:0] wa;
            wa = 5'($urandom_range(0, 7));
            drive(1'($urandom), wa, $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
                  ($urandom % 2 == 0) ? wa : 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_step();
            chk("rand2_data", rd_data, {e_data[1], e_data[0]});
            chk("rand2_pend", {62'd0, rd_pending}, {62'd0, e_pend[1], e_pend[0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
